// File: rtl/mmio_pkg.sv
// Register map and field positions shared by the peripheral bank and its software-facing bench.
// Pure constants: no latency or backpressure.
package mmio_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h10;
    localparam logic [4:0] OFF_CNT    = 5'h11;
    localparam logic [4:0] OFF_CMP    = 5'h12;
    localparam logic [4:0] OFF_STATUS = 5'h13;
    localparam logic [4:0] OFF_TXDATA = 5'h14;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    localparam int ST_MATCH     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_LEVEL_LSB = 8;

endpackage

// File: rtl/mmio_periph_bank_sync_fifo.sv
// First-word-fall-through synchronous FIFO; dout shows the head entry with no read latency.
// Latency: push visible on dout/empty one cycle later; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_periph_bank.sv
// MMIO bank: output registers, prescaled compare timer with irq, byte TX FIFO with valid/ready drain.
// Latency: reads combinational, writes visible next cycle; tx drain is valid/ready, TXDATA writes when full are dropped and flag OVF.
module mmio_periph_bank
    import mmio_pkg::*;
#(
    parameter int N_OUT      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int PRESCALE   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sel,
    input  logic                        we,
    input  logic [4:0]                  addr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [N_OUT*DATA_WIDTH-1:0] out_data,
    output logic                        irq,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [DATA_WIDTH-1:0] out_q [N_OUT];
    logic [DATA_WIDTH-1:0] out_d [N_OUT];
    logic [2:0]            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
    logic                  match_q, match_d;
    logic                  ovf_q, ovf_d;
    logic [PW-1:0]         presc_q, presc_d;

    logic          wr_en, tx_wr, presc_wrap, tick, hit;
    logic          fifo_push, fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [7:0]    fifo_dout;

    assign wr_en      = sel & we;
    assign tx_wr      = wr_en & (addr == OFF_TXDATA);
    assign fifo_push  = tx_wr & ~fifo_full;
    assign presc_wrap = (presc_q == PW'(PRESCALE - 1));
    assign tick       = ctrl_q[CTRL_EN] & presc_wrap;
    assign hit        = tick & (cnt_q == cmp_q);

    assign irq      = match_q & ctrl_q[CTRL_IE];
    assign tx_valid = ~fifo_empty;
    assign tx_data  = fifo_dout;

    always_comb begin
        out_d   = out_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        cmp_d   = cmp_q;
        match_d = match_q;
        ovf_d   = ovf_q;
        presc_d = presc_q;

        if (ctrl_q[CTRL_EN]) presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        if (tick) cnt_d = (hit & ctrl_q[CTRL_AR]) ? '0 : cnt_q + 1'b1;

        // Software writes override the timer; flag sets below then override W1C.
        if (wr_en) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (addr == 5'(i)) out_d[i] = wdata;
            end
            case (addr)
                OFF_CTRL:   ctrl_d = wdata[2:0];
                OFF_CNT:    cnt_d  = wdata;
                OFF_CMP:    cmp_d  = wdata;
                OFF_STATUS: begin
                    if (wdata[ST_MATCH]) match_d = 1'b0;
                    if (wdata[ST_OVF])   ovf_d   = 1'b0;
                end
                default: ;
            endcase
        end
        if (hit) match_d = 1'b1;
        if (tx_wr & fifo_full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '{default: '0};
            ctrl_q  <= '0;
            cnt_q   <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
        end else begin
            out_q   <= out_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (addr == 5'(i)) rdata = out_q[i];
            end
            case (addr)
                OFF_CTRL:   rdata = DATA_WIDTH'(ctrl_q);
                OFF_CNT:    rdata = cnt_q;
                OFF_CMP:    rdata = cmp_q;
                OFF_STATUS: begin
                    rdata           = DATA_WIDTH'(fifo_level) << ST_LEVEL_LSB;
                    rdata[ST_MATCH] = match_q;
                    rdata[ST_FULL]  = fifo_full;
                    rdata[ST_EMPTY] = fifo_empty;
                    rdata[ST_OVF]   = ovf_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N_OUT; i++) out_data[i*DATA_WIDTH +: DATA_WIDTH] = out_q[i];
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (tx_valid & tx_ready),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule
